// File: rtl/cpu_pkg.sv
// Shared types for the load/store path: FSM encoding, access-size codes and
// the alignment / byte-enable helpers used when a request is accepted.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a memory word and extends it.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  mem_size_e   size_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        data_o  = shifted;
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the EX/MEM register and a
// single-port memory: lane steering, ack timeout and load write-back.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op_read,
    input  logic        op_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        err
);

    localparam logic [4:0] LAST_WAIT = 5'(TIMEOUT - 1);

    mau_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    mem_size_e   size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        bad_req;
    mem_size_e   size_in;
    logic [31:0] load_data;

    assign size_in = mem_size_e'(size);
    assign accept  = in_valid && (op_read ^ op_write);
    assign bad_req = is_misaligned(size_in, addr[1:0]) || (size_in == SZ_ILL);

    load_align u_load_align (
        .word_i     (rdata_q),
        .offset_i   (off_q),
        .size_i     (size_q),
        .sign_ext_i (sign_q),
        .data_o     (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        in_ready = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        wb_valid = 1'b0;
        wb_data  = 32'h0;
        err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rstn gate keeps in_ready low while reset is held
                in_ready = rstn;
                if (accept) begin
                    we_d    = op_write;
                    size_d  = size_in;
                    sign_d  = sign_ext;
                    off_d   = addr[1:0];
                    addr_d  = {addr[31:2], 2'b00};
                    wdata_d = wdata << {addr[1:0], 3'b000};
                    be_d    = byte_enables(size_in, addr[1:0]);
                    pc_d    = pc_in;
                    rdata_d = 32'h0;
                    cnt_d   = 5'd0;
                    err_d   = bad_req;
                    state_d = bad_req ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                cnt_d   = 5'd0;
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_we = we_q;
                cnt_d  = cnt_q + 5'd1;
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_valid = 1'b1;
                err      = err_q;
                // stores and aborted accesses return zero
                wb_data  = (we_q || err_q) ? 32'h0 : load_data;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign wb_pc     = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change and outputs are sampled on
// the falling clock edge; each task checks one scenario inline.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, op_read, op_write, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata, pc_in;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, err;
    logic [31:0] wb_data, wb_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_read   (op_read),
        .op_write  (op_write),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .pc_in     (pc_in),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_pc     (wb_pc),
        .err       (err)
    );

    // Presents a request for one cycle; returns on the falling edge after acceptance.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        in_valid = 1'b1; op_read = rd; op_write = wr; size = sz; sign_ext = se;
        addr = a; wdata = wd; pc_in = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        in_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; size = 2'b10;
        addr = 32'h100; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if ({mem_req, mem_we, wb_valid, err} !== 4'b0) begin failures++; $display("FAIL reset_strobes: got %b want 0000", {mem_req, mem_we, wb_valid, err}); end
        checks++; if ({mem_addr, mem_wdata, wb_data, wb_pc, mem_be} !== 132'h0) begin failures++; $display("FAIL reset_buses: addr %h wdata %h wb_data %h wb_pc %h be %b want all 0", mem_addr, mem_wdata, wb_data, wb_pc, mem_be); end
        in_valid = 1'b0; mem_ack = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_word_load();
        logic early;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0400);
        checks++; if ({mem_req, mem_we} !== 2'b10) begin failures++; $display("FAIL wload_req: got req/we %b want 10", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h100 || mem_be !== 4'hF) begin failures++; $display("FAIL wload_addr_be: got %h/%b want 00000100/1111", mem_addr, mem_be); end
        early = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (mem_req || wb_valid || mem_addr !== 32'h100) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL wload_wait: got unexpected req/valid/addr change %b want 0", early); end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        checks++; if ({wb_valid, err} !== 2'b10) begin failures++; $display("FAIL wload_done: got valid/err %b want 10", {wb_valid, err}); end
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wload_data: got %h want deadbeef", wb_data); end
        checks++; if (wb_pc !== 32'h400) begin failures++; $display("FAIL wload_pc: got %h want 00000400", wb_pc); end
        @(negedge clk);
        checks++; if ({wb_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL wload_idle: got valid/ready %b want 01", {wb_valid, in_ready}); end
    endtask

    task automatic test_subword_load();
        logic [31:0] a_tab [3]  = '{32'h103, 32'h103, 32'h102};
        logic [1:0]  sz_tab [3] = '{2'b00, 2'b00, 2'b01};
        logic        se_tab [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0]  be_tab [3] = '{4'b1000, 4'b1000, 4'b1100};
        logic [31:0] exp_tab [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011};
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b0, sz_tab[i], se_tab[i], a_tab[i], 32'h0, 32'h500 + 32'(i));
            // ack during the request cycle: shortest path to write-back
            mem_ack = 1'b1; mem_rdata = 32'h8011_2233;
            checks++; if (mem_be !== be_tab[i] || mem_addr !== 32'h100) begin failures++; $display("FAIL subload_be[%0d]: got %b/%h want %b/00000100", i, mem_be, mem_addr, be_tab[i]); end
            @(negedge clk);
            mem_ack = 1'b0;
            checks++; if (wb_valid !== 1'b1 || wb_data !== exp_tab[i]) begin failures++; $display("FAIL subload_data[%0d]: got valid %b data %h want 1 %h", i, wb_valid, wb_data, exp_tab[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_stores();
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h600);
        checks++; if ({mem_req, mem_we} !== 2'b11 || mem_be !== 4'b1100) begin failures++; $display("FAIL hstore_req: got req/we %b be %b want 11 1100", {mem_req, mem_we}, mem_be); end
        checks++; if (mem_wdata !== 32'hABCD_0000 || mem_addr !== 32'h200) begin failures++; $display("FAIL hstore_data: got %h@%h want abcd0000@00000200", mem_wdata, mem_addr); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || mem_wdata !== 32'hABCD_0000 || mem_be !== 4'b1100) begin failures++; $display("FAIL hstore_hold: got req %b wdata %h be %b want 0 abcd0000 1100", mem_req, mem_wdata, mem_be); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if ({wb_valid, err} !== 2'b10 || wb_data !== 32'h0) begin failures++; $display("FAIL hstore_done: got valid/err %b data %h want 10 00000000", {wb_valid, err}, wb_data); end
        // back-to-back: next request issued on the first idle cycle
        @(negedge clk);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h604);
        checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h0000_A500) begin failures++; $display("FAIL bstore_lane: got be %b wdata %h want 0010 0000a500", mem_be, mem_wdata); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_pc !== 32'h604) begin failures++; $display("FAIL bstore_done: got valid %b pc %h want 1 00000604", wb_valid, wb_pc); end
        @(negedge clk);
    endtask

    task automatic test_rejects();
        // misaligned word load completes with err and never touches memory
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h700);
        checks++; if ({mem_req, wb_valid, err} !== 3'b011) begin failures++; $display("FAIL misalign: got req/valid/err %b want 011", {mem_req, wb_valid, err}); end
        @(negedge clk);
        // illegal size
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h704);
        checks++; if ({mem_req, wb_valid, err} !== 3'b011) begin failures++; $display("FAIL illegal_size: got req/valid/err %b want 011", {mem_req, wb_valid, err}); end
        @(negedge clk);
        // read and write both set: ignored
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h708);
        checks++; if ({in_ready, mem_req, wb_valid} !== 3'b100) begin failures++; $display("FAIL bad_op_ignored: got ready/req/valid %b want 100", {in_ready, mem_req, wb_valid}); end
        op_read = 1'b0; op_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic early;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h800);
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (wb_valid || mem_req) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL timeout_early: got early completion %b want 0", early); end
        @(negedge clk);
        checks++; if ({wb_valid, err} !== 2'b11 || wb_data !== 32'h0) begin failures++; $display("FAIL timeout_done: got valid/err %b data %h want 11 00000000", {wb_valid, err}, wb_data); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if ({wb_valid, mem_req, in_ready} !== 3'b001) begin failures++; $display("FAIL late_ack: got valid/req/ready %b want 001", {wb_valid, mem_req, in_ready}); end
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h900);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if ({in_ready, mem_req, wb_valid, err} !== 4'b0) begin failures++; $display("FAIL rst_wait_strobes: got %b want 0000", {in_ready, mem_req, wb_valid, err}); end
        checks++; if ({mem_addr, mem_be, wb_pc} !== 68'h0) begin failures++; $display("FAIL rst_wait_buses: got addr %h be %b pc %h want 0", mem_addr, mem_be, wb_pc); end
        @(negedge clk);
        rstn = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (wb_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_wait_no_wb: got wb_valid seen %b want 0", seen); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_wait_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; op_read = 1'b0; op_write = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0; pc_in = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_word_load();
        test_subword_load();
        test_stores();
        test_rejects();
        test_timeout();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish before 100us");
        $fatal(1, "watchdog expired");
    end

endmodule
